// File: rtl/ar_pkg.sv
// Shared definitions for the address register: default width, source-select
// encodings and the address type.
package ar_pkg;

  parameter int unsigned AR_WIDTH = 8;

  localparam logic SEL_BUS = 1'b0;
  localparam logic SEL_IMM = 1'b1;

  typedef logic [AR_WIDTH-1:0] addr_t;

endpackage

// File: rtl/ar_src_mux.sv
// Load-source mux for the address register.
// Selects the shared data bus or the instruction immediate field.
module ar_src_mux
  import ar_pkg::*;
#(
  parameter int unsigned WIDTH = AR_WIDTH
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] busIn,
  input  logic [WIDTH-1:0] immIn,
  output logic [WIDTH-1:0] muxOut
);

  always_comb begin
    muxOut = busIn;
    if (sel == SEL_IMM) begin
      muxOut = immIn;
    end
  end

endmodule

// File: rtl/ar.sv
// Per-core address register.
// It loads from the bus or the immediate, or it advances by the core stride.
module ar
  import ar_pkg::*;
#(
  parameter int unsigned WIDTH = AR_WIDTH
) (
  input  logic             Clk,
  input  logic             rstN,
  input  logic             WEN,
  input  logic             selAR,
  input  logic [WIDTH-1:0] BusOut,
  input  logic [WIDTH-1:0] IOut,
  input  logic             coreINC_AR,
  input  logic [WIDTH-1:0] coreID,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] arQ;
  logic [WIDTH-1:0] arD;
  logic [WIDTH-1:0] loadVal;

  ar_src_mux #(
    .WIDTH (WIDTH)
  ) uSrcMux (
    .sel    (selAR),
    .busIn  (BusOut),
    .immIn  (IOut),
    .muxOut (loadVal)
  );

  // A load takes priority; a simultaneous increment is dropped, not deferred.
  always_comb begin
    arD = arQ;
    if (WEN) begin
      arD = loadVal;
    end else if (coreINC_AR) begin
      arD = arQ + coreID;
    end
  end

  // The reset branch is tested first, so X on the controls cannot leak into AR.
  always_ff @(posedge Clk) begin
    if (!rstN) begin
      arQ <= '0;
    end else begin
      arQ <= arD;
    end
  end

  assign dout = arQ;

endmodule

// File: tb/tb_ar.sv
// Self-checking bench for ar.
// It runs directed steps and then a random run against an arithmetic reference model.
module tb_ar;

  localparam int unsigned W = 8;

  logic         Clk = 1'b0;
  logic         rstN;
  logic         WEN;
  logic         selAR;
  logic [W-1:0] BusOut;
  logic [W-1:0] IOut;
  logic         coreINC_AR;
  logic [W-1:0] coreID;
  logic [W-1:0] dout;

  int total = 0;
  int bad   = 0;
  int unsigned model = 0;

  ar #(
    .WIDTH (W)
  ) dut (
    .Clk        (Clk),
    .rstN       (rstN),
    .WEN        (WEN),
    .selAR      (selAR),
    .BusOut     (BusOut),
    .IOut       (IOut),
    .coreINC_AR (coreINC_AR),
    .coreID     (coreID),
    .dout       (dout)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  // Applies one cycle of inputs, advances the reference model and compares dout with it.
  task automatic step(input logic r, input logic wen, input logic sel, input logic inc,
                      input logic [W-1:0] bus, input logic [W-1:0] imm,
                      input logic [W-1:0] id, input string tag);
    rstN = r; WEN = wen; selAR = sel; coreINC_AR = inc;
    BusOut = bus; IOut = imm; coreID = id;
    @(posedge Clk);
    if (r !== 1'b1)          model = 0;
    else if (wen === 1'b1)   model = (sel === 1'b1) ? int'(imm) : int'(bus);
    else if (inc === 1'b1)   model = (model + int'(id)) % (1 << W);
    #1;
    check(tag, dout, model[W-1:0]);
  endtask

  task automatic stepExp(input logic r, input logic wen, input logic sel, input logic inc,
                         input logic [W-1:0] bus, input logic [W-1:0] imm,
                         input logic [W-1:0] id, input logic [W-1:0] want, input string tag);
    step(r, wen, sel, inc, bus, imm, id, tag);
    check({tag, "_const"}, dout, want);
  endtask

  initial begin
    // Reset, first with X on the controls and then with random controls.
    stepExp(1'b0, 1'bx, 1'bx, 1'bx, 8'($urandom), 8'($urandom), 8'($urandom), 8'h00, "rst_x");
    stepExp(1'b0, 1'($urandom), 1'($urandom), 1'($urandom),
            8'($urandom), 8'($urandom), 8'($urandom), 8'h00, "rst_rand");
    stepExp(1'b1, 1'b0, 1'b1, 1'b0, 8'h5A, 8'hA5, 8'h11, 8'h00, "rst_release");

    // Bus load, then hold.
    stepExp(1'b1, 1'b1, 1'b0, 1'b0, 8'hAA, 8'h88, 8'h00, 8'hAA, "bus_load");
    stepExp(1'b1, 1'b0, 1'b1, 1'b0, 8'h12, 8'h34, 8'h77, 8'hAA, "hold");

    // Increment by 1 for three cycles.
    stepExp(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h01, 8'hAB, "inc1_a");
    stepExp(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h01, 8'hAC, "inc1_b");
    stepExp(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h01, 8'hAD, "inc1_c");

    // Wrap-around cases.
    stepExp(1'b1, 1'b1, 1'b0, 1'b0, 8'hFE, 8'h00, 8'h00, 8'hFE, "load_fe");
    stepExp(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h04, 8'h02, "wrap_fe_4");
    stepExp(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'hFF, 8'h00, 8'hFF, "imm_ff");
    stepExp(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h01, 8'h00, "wrap_ff_1");

    // Immediate load beats a simultaneous increment.
    stepExp(1'b1, 1'b1, 1'b1, 1'b1, 8'hAA, 8'h88, 8'h01, 8'h88, "imm_prio");
    // Reset beats both the load and the increment.
    stepExp(1'b0, 1'b1, 1'b0, 1'b1, 8'h3C, 8'h88, 8'h01, 8'h00, "rst_prio");

    // Random regression. Reset is asserted about 1 cycle in 16.
    for (int i = 0; i < 1000; i++) begin
      step(($urandom_range(15) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
           8'($urandom), 8'($urandom), 8'($urandom), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
